// File: rtl/sys_bus_pkg.sv
// Shared types and helpers for the system-bus arbiter.
// Imported by the decoder and the top.
package sys_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic M_INST = 1'b0;
  localparam logic M_DATA = 1'b1;

  function automatic int cnt_width(input int tmo);
    return $clog2(tmo + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Reserved size code counts as a bad access too.
  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] lsb
  );
    return (size == 2'b11)
        || (size == SZ_HALF && lsb[0])
        || (size == SZ_WORD && lsb != 2'b00);
  endfunction

endpackage

// File: rtl/sys_bus_decoder.sv
// Address decoder: first (lowest-index) matching region wins.
// Purely combinational.
module sys_bus_decoder
  import sys_bus_pkg::*;
#(
  parameter int NUM_SLV = 4,
  parameter int IDX_W   = idx_width(NUM_SLV)
) (
  input  logic [31:0]            addr,
  input  logic [32*NUM_SLV-1:0]  base,
  input  logic [32*NUM_SLV-1:0]  mask,
  output logic                   hit,
  output logic [NUM_SLV-1:0]     sel,
  output logic [IDX_W-1:0]       idx
);

  always_comb begin
    hit = 1'b0;
    sel = '0;
    idx = '0;
    // Walk downwards so the lowest match is written last.
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if ((addr & mask[32*i +: 32]) == base[32*i +: 32]) begin
        hit    = 1'b1;
        sel    = '0;
        sel[i] = 1'b1;
        idx    = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/sys_bus_arb.sv
// Two-master, NUM_SLV-slave system bus: round-robin arbiter,
// address decode, one transaction in flight, error responses.
module sys_bus_arb
  import sys_bus_pkg::*;
#(
  parameter int NUM_SLV = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter logic [32*NUM_SLV-1:0] SLV_BASE = {NUM_SLV{32'h0}},
  parameter logic [32*NUM_SLV-1:0] SLV_MASK = {NUM_SLV{32'h0}}
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      m0_req,
  input  logic [31:0]               m0_addr,
  output logic [DATA_W-1:0]         m0_rdata,
  output logic                      m0_ready,
  output logic                      m0_err,
  input  logic                      m1_req,
  input  logic                      m1_we,
  input  logic [31:0]               m1_addr,
  input  logic [DATA_W-1:0]         m1_wdata,
  input  logic [1:0]                m1_size,
  output logic [DATA_W-1:0]         m1_rdata,
  output logic                      m1_ready,
  output logic                      m1_err,
  output logic [NUM_SLV-1:0]        s_req,
  output logic                      s_we,
  output logic [31:0]               s_addr,
  output logic [DATA_W-1:0]         s_wdata,
  output logic [1:0]                s_size,
  input  logic [NUM_SLV*DATA_W-1:0] s_rdata,
  input  logic [NUM_SLV-1:0]        s_ready
);

  localparam int CNT_W = cnt_width(TIMEOUT);
  localparam int IDX_W = idx_width(NUM_SLV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t             state;
  logic               gnt;
  logic               last_gnt;
  logic [IDX_W-1:0]   sel_idx;
  logic [CNT_W-1:0]   cnt;

  logic               any_req;
  logic               nxt_gnt;
  logic [31:0]        c_addr;
  logic               c_we;
  logic [DATA_W-1:0]  c_wdata;
  logic [1:0]         c_size;
  logic               bad;

  logic               dec_hit;
  logic [NUM_SLV-1:0] dec_sel;
  logic [IDX_W-1:0]   dec_idx;

  logic               slv_rdy;
  logic [DATA_W-1:0]  slv_rdata;

  logic               rsp_fire;
  logic               rsp_err;
  logic               rsp_m;
  logic [DATA_W-1:0]  rsp_data;

  assign any_req = m0_req | m1_req;

  // On a tie the master that did not win last time is granted.
  always_comb begin
    nxt_gnt = M_INST;
    if (m0_req && m1_req) begin
      nxt_gnt = (last_gnt == M_INST) ? M_DATA : M_INST;
    end else if (m1_req) begin
      nxt_gnt = M_DATA;
    end
  end

  always_comb begin
    c_addr  = m0_addr;
    c_we    = 1'b0;
    c_wdata = '0;
    c_size  = SZ_WORD;
    if (nxt_gnt == M_DATA) begin
      c_addr  = m1_addr;
      c_we    = m1_we;
      c_wdata = m1_wdata;
      c_size  = m1_size;
    end
  end

  assign bad = misaligned(c_size, c_addr[1:0]);

  sys_bus_decoder #(
    .NUM_SLV (NUM_SLV),
    .IDX_W   (IDX_W)
  ) u_dec (
    .addr (c_addr),
    .base (SLV_BASE),
    .mask (SLV_MASK),
    .hit  (dec_hit),
    .sel  (dec_sel),
    .idx  (dec_idx)
  );

  always_comb begin
    slv_rdy   = 1'b0;
    slv_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        slv_rdy   = s_ready[i];
        slv_rdata = s_rdata[DATA_W*i +: DATA_W];
      end
    end
  end

  always_comb begin
    rsp_fire = 1'b0;
    rsp_err  = 1'b0;
    rsp_m    = gnt;
    rsp_data = '0;
    unique case (state)
      ST_IDLE: begin
        if (any_req && (!dec_hit || bad)) begin
          rsp_fire = 1'b1;
          rsp_err  = 1'b1;
          rsp_m    = nxt_gnt;
        end
      end
      ST_ACCESS: begin
        if (slv_rdy) begin
          rsp_fire = 1'b1;
          rsp_data = s_we ? '0 : slv_rdata;
        end else if (cnt == CNT_LAST) begin
          rsp_fire = 1'b1;
          rsp_err  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      gnt      <= M_INST;
      last_gnt <= M_DATA;
      sel_idx  <= '0;
      cnt      <= '0;
      s_req    <= '0;
      s_we     <= 1'b0;
      s_addr   <= '0;
      s_wdata  <= '0;
      s_size   <= '0;
      m0_ready <= 1'b0;
      m0_err   <= 1'b0;
      m0_rdata <= '0;
      m1_ready <= 1'b0;
      m1_err   <= 1'b0;
      m1_rdata <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (any_req) begin
            gnt     <= nxt_gnt;
            s_we    <= c_we;
            s_addr  <= c_addr;
            s_wdata <= c_wdata;
            s_size  <= c_size;
            sel_idx <= dec_idx;
            cnt     <= '0;
            if (rsp_fire) begin
              state <= ST_RESP;
            end else begin
              state <= ST_ACCESS;
              s_req <= dec_sel;
            end
          end
        end
        ST_ACCESS: begin
          cnt <= cnt + 1'b1;
          if (rsp_fire) begin
            s_req <= '0;
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          m0_ready <= 1'b0;
          m0_err   <= 1'b0;
          m0_rdata <= '0;
          m1_ready <= 1'b0;
          m1_err   <= 1'b0;
          m1_rdata <= '0;
          last_gnt <= gnt;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      if (rsp_fire) begin
        if (rsp_m == M_DATA) begin
          m1_ready <= 1'b1;
          m1_err   <= rsp_err;
          m1_rdata <= rsp_data;
        end else begin
          m0_ready <= 1'b1;
          m0_err   <= rsp_err;
          m0_rdata <= rsp_data;
        end
      end
    end
  end

endmodule
